// File: rtl/mt6835_angle_proc.sv
// MT6835 frame post-processing: bit-serial CRC-8, angle forwarding, electrical angle, faults.
// Optional velocity output when MT6835_VELOCITY_EN is defined.
module mt6835_angle_proc #(
  parameter int POLE_PAIRS  = 7,
  parameter int ERR_LIMIT   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [20:0] i_angle,
  input  logic [2:0]  i_status,
  input  logic [7:0]  i_crc,
  input  logic [20:0] i_offset,
  output logic        o_valid,
  output logic [20:0] o_mech_angle,
  output logic [20:0] o_elec_angle,
  output logic [2:0]  o_status,
  output logic        o_crc_err,
  output logic        o_overrun,
  output logic [15:0] o_err_cnt,
  output logic        o_fault
`ifdef MT6835_VELOCITY_EN
  ,
  output logic signed [20:0] o_velocity
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);
  localparam logic [7:0] LIM = 8'(ERR_LIMIT);
  localparam logic [3:0] PP = 4'(POLE_PAIRS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CRC   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_CALC  = 2'd3;

  logic [1:0]    state;
  logic [23:0]   shreg;
  logic [7:0]    crc_q;
  logic [7:0]    crc_lat;
  logic [20:0]   ang_q;
  logic [2:0]    sta_q;
  logic [20:0]   off_q;
  logic [4:0]    bit_cnt;
  logic          err_pend;
  logic [7:0]    consec;
  logic [TW-1:0] tmo;

  logic          fb;
  logic [7:0]    crc_next;
  logic [24:0]   prod;
  logic [20:0]   elec;

  assign fb       = crc_q[7] ^ shreg[23];
  assign crc_next = {crc_q[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  assign prod     = {4'b0, ang_q} * {21'b0, PP};
  assign elec     = prod[20:0] - off_q;

  assign o_fault   = (consec >= LIM) | (tmo == TMO_MAX);
  assign o_overrun = i_valid & (state != S_IDLE);

`ifdef MT6835_VELOCITY_EN
  logic have_prev;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      shreg        <= '0;
      crc_q        <= '0;
      crc_lat      <= '0;
      ang_q        <= '0;
      sta_q        <= '0;
      off_q        <= '0;
      bit_cnt      <= '0;
      err_pend     <= 1'b0;
      consec       <= '0;
      tmo          <= '0;
      o_valid      <= 1'b0;
      o_mech_angle <= '0;
      o_elec_angle <= '0;
      o_status     <= '0;
      o_crc_err    <= 1'b0;
      o_err_cnt    <= '0;
`ifdef MT6835_VELOCITY_EN
      have_prev    <= 1'b0;
      o_velocity   <= '0;
`endif
    end else begin
      o_valid   <= 1'b0;
      o_crc_err <= 1'b0;

      if (i_valid)
        tmo <= '0;
      else if (tmo != TMO_MAX)
        tmo <= tmo + 1'b1;

      // Mismatch is reported one cycle after CHECK to align with the good-frame pulse
      if (err_pend) begin
        err_pend  <= 1'b0;
        o_crc_err <= 1'b1;
        if (o_err_cnt != 16'hFFFF)
          o_err_cnt <= o_err_cnt + 16'd1;
        if (consec != 8'hFF)
          consec <= consec + 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (i_valid) begin
            ang_q   <= i_angle;
            sta_q   <= i_status;
            crc_lat <= i_crc;
            off_q   <= i_offset;
            shreg   <= {i_angle, i_status};
            crc_q   <= 8'h00;
            bit_cnt <= '0;
            state   <= S_CRC;
          end
        end
        S_CRC: begin
          crc_q   <= crc_next;
          shreg   <= {shreg[22:0], 1'b0};
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd23)
            state <= S_CHECK;
        end
        S_CHECK: begin
          if (crc_q == crc_lat) begin
            state <= S_CALC;
          end else begin
            err_pend <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_CALC: begin
          o_mech_angle <= ang_q;
          o_status     <= sta_q;
          o_elec_angle <= elec;
          o_valid      <= 1'b1;
          consec       <= '0;
`ifdef MT6835_VELOCITY_EN
          have_prev    <= 1'b1;
          if (!have_prev || o_fault)
            o_velocity <= '0;
          else
            o_velocity <= ang_q - o_mech_angle;
`endif
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mt6835_angle_proc.sv
// Self-checking bench for mt6835_angle_proc: per-cycle model compare plus directed literals.
// Define MT6835_VELOCITY_EN to also exercise o_velocity.
module tb_mt6835_angle_proc;

  localparam int PP   = 7;
  localparam int LIM  = 4;
  localparam int TMOC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [20:0] i_angle = '0;
  logic [2:0]  i_status = '0;
  logic [7:0]  i_crc = '0;
  logic [20:0] i_offset = '0;
  logic        o_valid;
  logic [20:0] o_mech_angle;
  logic [20:0] o_elec_angle;
  logic [2:0]  o_status;
  logic        o_crc_err;
  logic        o_overrun;
  logic [15:0] o_err_cnt;
  logic        o_fault;
`ifdef MT6835_VELOCITY_EN
  logic [20:0] o_velocity;
`endif

  always #5 clk = ~clk;

  mt6835_angle_proc #(
    .POLE_PAIRS (PP),
    .ERR_LIMIT  (LIM),
    .TIMEOUT_CYC(TMOC)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .i_angle     (i_angle),
    .i_status    (i_status),
    .i_crc       (i_crc),
    .i_offset    (i_offset),
    .o_valid     (o_valid),
    .o_mech_angle(o_mech_angle),
    .o_elec_angle(o_elec_angle),
    .o_status    (o_status),
    .o_crc_err   (o_crc_err),
    .o_overrun   (o_overrun),
    .o_err_cnt   (o_err_cnt),
    .o_fault     (o_fault)
`ifdef MT6835_VELOCITY_EN
    ,
    .o_velocity  (o_velocity)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC as the remainder of polynomial division of data*x^8 by 0x107
  function automatic logic [7:0] crc_ref(input logic [20:0] a,
                                         input logic [2:0] s);
    logic [31:0] r;
    r = {a, s, 8'h00};
    for (int i = 31; i >= 8; i--)
      if (r[i]) r = r ^ (32'h107 << (i - 8));
    return r[7:0];
  endfunction

  // Model state
  int          cyc = 0;
  logic [20:0] m_mech = '0;
  logic [20:0] m_elec = '0;
  logic [2:0]  m_status = '0;
  logic [20:0] m_vel = '0;
  int          m_errcnt = 0;
  int          m_consec = 0;
  int          m_tmo = 0;
  bit          m_have_prev = 0;
  bit          e_valid = 0;
  bit          e_crc_err = 0;
  bit          pend = 0;
  int          pN = 0;
  bit          p_good = 0;
  logic [20:0] p_angle = '0;
  logic [2:0]  p_status = '0;
  logic [20:0] p_off = '0;

  function automatic bit busy_at(input int c);
    return pend && c >= pN && c <= pN + (p_good ? 25 : 24);
  endfunction

  function automatic bit model_fault();
    return (m_consec >= LIM) || (m_tmo == TMOC);
  endfunction

  initial forever begin
    bit accept_ok;
    @(posedge clk or posedge rst);
    if (rst) begin
      cyc = 0; m_mech = '0; m_elec = '0; m_status = '0; m_vel = '0;
      m_errcnt = 0; m_consec = 0; m_tmo = 0; m_have_prev = 0;
      e_valid = 0; e_crc_err = 0; pend = 0;
    end else begin
      cyc++;
      accept_ok = !busy_at(cyc - 1);
      e_valid = 0;
      e_crc_err = 0;
      if (pend && cyc == pN + 26) begin
        if (p_good) begin
          m_vel = (!m_have_prev || model_fault()) ? 21'd0
                                                  : 21'(p_angle - m_mech);
          m_have_prev = 1;
          m_mech = p_angle;
          m_status = p_status;
          m_elec = 21'(21'(p_angle * PP) - p_off);
          m_consec = 0;
          e_valid = 1;
        end else begin
          e_crc_err = 1;
          if (m_errcnt < 65535) m_errcnt++;
          if (m_consec < 255) m_consec++;
        end
        pend = 0;
      end
      if (i_valid) m_tmo = 0;
      else if (m_tmo < TMOC) m_tmo++;
      if (i_valid && accept_ok) begin
        pend = 1;
        pN = cyc;
        p_angle = i_angle;
        p_status = i_status;
        p_off = i_offset;
        p_good = (crc_ref(i_angle, i_status) == i_crc);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("valid", 32'(o_valid), 32'(e_valid));
    chk("crc_err", 32'(o_crc_err), 32'(e_crc_err));
    chk("overrun", 32'(o_overrun), 32'(i_valid && busy_at(cyc)));
    chk("fault", 32'(o_fault), 32'(model_fault()));
    chk("mech", 32'(o_mech_angle), 32'(m_mech));
    chk("elec", 32'(o_elec_angle), 32'(m_elec));
    chk("status", 32'(o_status), 32'(m_status));
    chk("err_cnt", 32'(o_err_cnt), 32'(m_errcnt));
`ifdef MT6835_VELOCITY_EN
    chk("velocity", 32'(o_velocity), 32'(m_vel));
`endif
  end

  task automatic send(input logic [20:0] a, input logic [2:0] s,
                      input logic [7:0] c, input logic [20:0] off);
    @(posedge clk);
    #1;
    i_angle = a; i_status = s; i_crc = c; i_offset = off;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_res(input string name, output int lat,
                          output bit good, output bit bad);
    lat = 0; good = 0; bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #2;
      if (o_valid || o_crc_err) begin
        lat = k; good = o_valid; bad = o_crc_err;
        return;
      end
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    bit good;
    bit bad;
    int nv;
    int nb;

    chk("crc_ref_001", 32'(crc_ref(21'd0, 3'd1)), 32'h07);
    chk("crc_ref_a1", 32'(crc_ref(21'd1, 3'd0)), 32'h38);
    chk("crc_ref_0", 32'(crc_ref(21'd0, 3'd0)), 32'h00);

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_mech", 32'(o_mech_angle), 32'd0);
    chk("rst_elec", 32'(o_elec_angle), 32'd0);
    chk("rst_errcnt", 32'(o_err_cnt), 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    repeat (4095) @(posedge clk);
    #2 chk("tmo_early", 32'(o_fault), 32'd0);
    @(posedge clk);
    #2 chk("tmo_fault", 32'(o_fault), 32'd1);

    send(21'd0, 3'd0, 8'h00, 21'd0);
    wait_res("t2", lat, good, bad);
    chk("t2_latency", 32'(lat), 32'd26);
    chk("t2_good", 32'(good), 32'd1);
    chk("t2_mech", 32'(o_mech_angle), 32'd0);
    chk("t2_elec", 32'(o_elec_angle), 32'd0);
    chk("t2_fault", 32'(o_fault), 32'd0);

    send(21'd0, 3'b001, 8'h07, 21'd0);
    wait_res("t3a", lat, good, bad);
    chk("t3a_good", 32'(good), 32'd1);
    chk("t3a_status", 32'(o_status), 32'd1);
    send(21'd1, 3'd0, 8'h38, 21'd0);
    wait_res("t3b", lat, good, bad);
    chk("t3b_good", 32'(good), 32'd1);
    chk("t3b_elec", 32'(o_elec_angle), 32'd7);

    send(21'h100000, 3'd0, crc_ref(21'h100000, 3'd0), 21'd0);
    wait_res("t4a", lat, good, bad);
    chk("t4a_elec", 32'(o_elec_angle), 32'h100000);
    send(21'd0, 3'd0, 8'h00, 21'd5);
    wait_res("t4b", lat, good, bad);
    chk("t4b_elec", 32'(o_elec_angle), 32'h1FFFFB);

    for (int n = 1; n <= 4; n++) begin
      send(21'd1, 3'd0, 8'h39, 21'd0);
      wait_res("t5_bad", lat, good, bad);
      chk("t5_crc_err", 32'(bad), 32'd1);
      chk("t5_fault", 32'(o_fault), 32'(n >= 4));
    end
    chk("t5_errcnt", 32'(o_err_cnt), 32'd4);
    chk("t5_mech", 32'(o_mech_angle), 32'd0);
    send(21'd1, 3'd0, 8'h38, 21'd0);
    wait_res("t5_good", lat, good, bad);
    chk("t5_recover", 32'(o_fault), 32'd0);
    chk("t5_errcnt2", 32'(o_err_cnt), 32'd4);

    send(21'd2, 3'd0, crc_ref(21'd2, 3'd0), 21'd0);
    repeat (8) @(posedge clk);
    @(posedge clk);
    #1;
    i_angle = 21'd9; i_status = 3'd0; i_crc = crc_ref(21'd9, 3'd0);
    i_valid = 1'b1;
    #1 chk("t6_overrun", 32'(o_overrun), 32'd1);
    @(posedge clk);
    #1 i_valid = 1'b0;
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #2 if (o_valid) nv++;
    end
    chk("t6_single_valid", 32'(nv), 32'd1);
    chk("t6_mech", 32'(o_mech_angle), 32'd2);

`ifdef MT6835_VELOCITY_EN
    send(21'h1FFFFE, 3'd0, crc_ref(21'h1FFFFE, 3'd0), 21'd0);
    wait_res("t7a", lat, good, bad);
    send(21'h000003, 3'd0, crc_ref(21'h000003, 3'd0), 21'd0);
    wait_res("t7b", lat, good, bad);
    chk("t7_velocity", 32'(o_velocity), 32'd5);
`endif

    send(21'd7, 3'd0, crc_ref(21'd7, 3'd0), 21'd0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t8_rst_mech", 32'(o_mech_angle), 32'd0);
    chk("t8_rst_errcnt", 32'(o_err_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    nv = 0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #2;
      if (o_valid) nv++;
      if (o_crc_err) nb++;
    end
    chk("t8_no_valid", 32'(nv), 32'd0);
    chk("t8_no_crc_err", 32'(nb), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
